// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage data memory.
//   size_t            : access size encoding carried on the size port
//   MMIO_ADDR_DEFAULT : byte address of the board result register
//   lane_enable()     : byte-lane write enables for a given size/lane
package mips_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  localparam logic [31:0] MMIO_ADDR_DEFAULT = 32'h0000_0090;

  function automatic logic [3:0] lane_enable(input size_t sz, input logic [1:0] lane);
    logic [3:0] en;
    case (sz)
      SZ_BYTE: en = 4'b0001 << lane;
      SZ_HALF: en = 4'b0011 << lane;
      SZ_WORD: en = 4'b1111;
      default: en = '0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/dmem_load_extend.sv
// Load lane select and sign/zero extension (combinational).
//   word     : full 32-bit memory word
//   lane     : byte offset of the access within the word
//   size     : access size
//   sign_ext : 1 sign-extends byte/half results, 0 zero-extends
//   data     : right-justified, extended load result
module dmem_load_extend
  import mips_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  size_t       size,
  input  logic        sign_ext,
  output logic [31:0] data
);

  logic [31:0] shifted;

  assign shifted = word >> {lane, 3'b000};

  always_comb begin
    data = word;
    case (size)
      SZ_BYTE: data = sign_ext ? {{24{shifted[7]}}, shifted[7:0]}
                               : {24'h0, shifted[7:0]};
      SZ_HALF: data = sign_ext ? {{16{shifted[15]}}, shifted[15:0]}
                               : {16'h0, shifted[15:0]};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/dmem_sized_access.sv
// MEM-stage data memory with byte/half/word access.
//   clock, reset     : rising-edge clock, synchronous active-high reset
//   address          : byte address
//   writeData        : right-justified store data
//   memWriteF/ReadF  : store / load request this cycle
//   size, signExt    : access size and load extension mode
//   readData         : registered load result, held until the next load
//   readValid        : one-cycle strobe for a completed load
//   fault            : one-cycle strobe after a rejected access
//   finalAnswer      : result register mapped at MMIO_ADDR
module dmem_sized_access
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 512,
  parameter int unsigned ADDR_W      = 32,
  parameter logic [31:0] MMIO_ADDR   = MMIO_ADDR_DEFAULT,
  parameter int unsigned MMIO_W      = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       writeData,
  input  logic              memWriteF,
  input  logic              memReadF,
  input  logic [1:0]        size,
  input  logic              signExt,
  output logic [31:0]       readData,
  output logic              readValid,
  output logic              fault,
  output logic [MMIO_W-1:0] finalAnswer
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  size_t             sz;
  logic [ADDR_W-3:0] word_idx;
  logic [IDX_W-1:0]  ram_idx;
  logic [1:0]        lane;
  logic              is_mmio;
  logic              out_of_range;
  logic              misaligned;
  logic              bad;
  logic              store_ok;
  logic              load_ok;
  logic              reject;
  logic [3:0]        byte_en;
  logic [31:0]       wdata_rep;
  logic [31:0]       ram_word;
  logic [31:0]       ext_data;
  logic [MMIO_W-1:0] mmio_reg;

  logic [31:0] mem [DEPTH_WORDS];

  assign sz       = size_t'(size);
  assign word_idx = address[ADDR_W-1:2];
  assign ram_idx  = word_idx[IDX_W-1:0];
  assign lane     = address[1:0];

  // The exact MMIO address is exempt from the range check even though it
  // may alias a RAM word; the other bytes of that word still reach RAM.
  assign is_mmio      = (address == ADDR_W'(MMIO_ADDR));
  assign out_of_range = !is_mmio && (word_idx >= (ADDR_W-2)'(DEPTH_WORDS));

  always_comb begin
    misaligned = 1'b1;
    case (sz)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = address[0];
      SZ_WORD: misaligned = |lane;
      default: misaligned = 1'b1;
    endcase
  end

  assign bad      = misaligned || out_of_range;
  assign store_ok = memWriteF && !bad;
  // A simultaneous store wins; the load is dropped and reported as a fault.
  assign load_ok  = memReadF && !memWriteF && !bad;
  assign reject   = (memWriteF || memReadF) && (bad || (memWriteF && memReadF));
  assign byte_en  = lane_enable(sz, lane);

  always_comb begin
    wdata_rep = writeData;
    case (sz)
      SZ_BYTE: wdata_rep = {4{writeData[7:0]}};
      SZ_HALF: wdata_rep = {2{writeData[15:0]}};
      default: wdata_rep = writeData;
    endcase
  end

  // RAM has no reset so it maps onto block RAM; reset only suppresses writes.
  always_ff @(posedge clock) begin
    if (!reset && store_ok && !is_mmio) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[ram_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mmio_reg <= '0;
    end else if (store_ok && is_mmio) begin
      for (int unsigned i = 0; i < MMIO_W; i++) begin
        if (byte_en[i/8]) mmio_reg[i] <= wdata_rep[i];
      end
    end
  end

  assign ram_word    = mem[ram_idx];
  assign finalAnswer = mmio_reg;

  dmem_load_extend u_load_extend (
    .word     (ram_word),
    .lane     (lane),
    .size     (sz),
    .sign_ext (signExt),
    .data     (ext_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      readData  <= '0;
      readValid <= 1'b0;
      fault     <= 1'b0;
    end else begin
      readValid <= load_ok;
      fault     <= reject;
      if (load_ok) readData <= is_mmio ? 32'(mmio_reg) : ext_data;
    end
  end

endmodule

// File: tb/tb_dmem_sized_access.sv
// Self-checking bench for dmem_sized_access: directed test-plan sequence
// followed by randomized traffic against a byte-addressed reference model.
module tb_dmem_sized_access;

  localparam int DW = 64;
  localparam logic [31:0] MMIO = 32'h0000_0090;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        memWriteF;
  logic        memReadF;
  logic [1:0]  size;
  logic        signExt;
  logic [31:0] readData;
  logic        readValid;
  logic        fault;
  logic [7:0]  finalAnswer;

  always #5 clock = ~clock;

  dmem_sized_access #(
    .DEPTH_WORDS (DW),
    .ADDR_W      (32),
    .MMIO_ADDR   (MMIO),
    .MMIO_W      (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .address     (address),
    .writeData   (writeData),
    .memWriteF   (memWriteF),
    .memReadF    (memReadF),
    .size        (size),
    .signExt     (signExt),
    .readData    (readData),
    .readValid   (readValid),
    .fault       (fault),
    .finalAnswer (finalAnswer)
  );

  // Reference model: flat byte array plus "has been written" flags.
  logic [7:0]  mb [4*DW];
  bit          mk [4*DW];
  logic [7:0]  m_mmio;
  logic [31:0] e_rd;
  bit          e_rd_known;
  bit          e_rv;
  bit          e_flt;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One request cycle: drive, predict, clock, compare.
  task automatic step(input bit rst, input bit we, input bit re, input logic [31:0] a,
                      input logic [31:0] wd, input logic [1:0] sz, input bit sx);
    bit          mmio;
    bit          bad;
    int          n;
    logic [31:0] v;
    reset     = rst;
    memWriteF = we;
    memReadF  = re;
    address   = a;
    writeData = wd;
    size      = sz;
    signExt   = sx;

    if (rst) begin
      e_rd = '0; e_rd_known = 1; e_rv = 0; e_flt = 0; m_mmio = '0;
    end else begin
      mmio = (a == MMIO);
      n    = 1 << sz;
      bad  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
             || (!mmio && (a / 4) >= DW);
      e_flt = (we || re) && (bad || (we && re));
      e_rv  = re && !we && !bad;
      if (we && !bad) begin
        if (mmio) m_mmio = wd[7:0];
        else for (int k = 0; k < n; k++) begin
          mb[a + k] = wd[8*k +: 8];
          mk[a + k] = 1;
        end
      end
      if (e_rv) begin
        if (mmio) begin
          e_rd = {24'h0, m_mmio}; e_rd_known = 1;
        end else begin
          v = '0; e_rd_known = 1;
          for (int k = 0; k < n; k++) begin
            if (!mk[a + k]) e_rd_known = 0;
            v[8*k +: 8] = mb[a + k];
          end
          if (sx && sz == 2'd0 && v[7])  v = v | 32'hFFFF_FF00;
          if (sx && sz == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
          e_rd = v;
        end
      end
    end

    @(posedge clock);
    #1;
    check("readValid", {31'h0, readValid}, {31'h0, e_rv});
    check("fault", {31'h0, fault}, {31'h0, e_flt});
    check("finalAnswer", {24'h0, finalAnswer}, {24'h0, m_mmio});
    if (e_rd_known) check("readData", readData, e_rd);
  endtask

  task automatic idle();
    step(0, 0, 0, '0, '0, 2'd2, 0);
  endtask

  initial begin
    bit          we, re, rst;
    logic [31:0] a;
    logic [1:0]  sz;
    int          r;
    for (int i = 0; i < 4*DW; i++) mk[i] = 0;
    m_mmio = '0; e_rd = '0; e_rd_known = 0;

    step(1, 0, 0, '0, '0, 2'd2, 0);
    check("rst_readData", readData, 32'h0);
    step(1, 0, 0, '0, '0, 2'd2, 0);

    // word store then load, single-cycle valid strobe
    step(0, 1, 0, 32'h10, 32'hDEADBEEF, 2'd2, 0);
    step(0, 0, 1, 32'h10, '0, 2'd2, 0);
    check("lw10", readData, 32'hDEADBEEF);
    check("lw10_valid", {31'h0, readValid}, 32'h1);
    idle();
    check("valid_one_cycle", {31'h0, readValid}, 32'h0);
    check("readData_hold", readData, 32'hDEADBEEF);

    // byte store, byte loads with both extensions
    step(0, 1, 0, 32'h11, 32'h0000005A, 2'd0, 0);
    step(0, 0, 1, 32'h10, '0, 2'd2, 0);
    check("lw10_sb", readData, 32'hDEAD5AEF);
    step(0, 0, 1, 32'h13, '0, 2'd0, 1);
    check("lb13", readData, 32'hFFFFFFDE);
    step(0, 0, 1, 32'h13, '0, 2'd0, 0);
    check("lbu13", readData, 32'h000000DE);

    // halfword store, loads, misaligned half
    step(0, 1, 0, 32'h22, 32'h00008001, 2'd1, 0);
    step(0, 0, 1, 32'h22, '0, 2'd1, 1);
    check("lh22", readData, 32'hFFFF8001);
    step(0, 0, 1, 32'h22, '0, 2'd1, 0);
    check("lhu22", readData, 32'h00008001);
    step(0, 0, 1, 32'h21, '0, 2'd1, 1);
    check("lh21_fault", {31'h0, fault}, 32'h1);
    check("lh21_valid", {31'h0, readValid}, 32'h0);
    step(0, 1, 0, 32'h21, 32'hFFFF, 2'd1, 0);
    step(0, 0, 1, 32'h22, '0, 2'd1, 0);
    check("lhu22_unchanged", readData, 32'h00008001);

    // MMIO result register
    step(0, 1, 0, MMIO, 32'h0000002A, 2'd2, 0);
    check("finalAnswer_2A", {24'h0, finalAnswer}, 32'h2A);
    step(0, 0, 1, MMIO, '0, 2'd2, 0);
    check("lw90", readData, 32'h0000002A);
    step(1, 0, 0, '0, '0, 2'd2, 0);
    check("finalAnswer_rst", {24'h0, finalAnswer}, 32'h0);

    // range fault and simultaneous store/load
    step(0, 0, 1, 4*DW, '0, 2'd2, 0);
    check("lw_range_fault", {31'h0, fault}, 32'h1);
    step(0, 1, 1, 32'h40, 32'h00001234, 2'd2, 0);
    check("wr_rd_fault", {31'h0, fault}, 32'h1);
    step(0, 0, 1, 32'h40, '0, 2'd2, 0);
    check("lw40", readData, 32'h00001234);

    // write-first on consecutive cycles, reset discards a store
    step(0, 1, 0, 32'h8, 32'h11111111, 2'd2, 0);
    step(0, 0, 1, 32'h8, '0, 2'd2, 0);
    check("lw8", readData, 32'h11111111);
    step(0, 1, 0, 32'hC, 32'h00000077, 2'd2, 0);
    step(1, 1, 0, 32'hC, 32'hCAFEF00D, 2'd2, 0);
    step(0, 0, 1, 32'hC, '0, 2'd2, 0);
    check("lwC_after_rst", readData, 32'h00000077);

    // preload every word so random loads have known data
    for (int w = 0; w < DW; w++) step(0, 1, 0, 32'(4*w), $urandom, 2'd2, 0);

    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 19);
      if (r < 14)       a = $urandom_range(0, 4*DW-1);
      else if (r < 16)  a = MMIO;
      else if (r < 18)  a = $urandom_range(4*DW, 4*DW+15);
      else              a = $urandom;
      r  = $urandom_range(0, 9);
      sz = (r < 9) ? 2'($urandom_range(0, 2)) : 2'd3;
      if (sz == 2'd2 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      if (sz == 2'd1 && $urandom_range(0, 3) != 0) a[0] = 1'b0;
      we  = ($urandom_range(0, 2) == 0);
      re  = ($urandom_range(0, 1) == 0);
      rst = ($urandom_range(0, 99) == 0);
      step(rst, we, re, a, $urandom, sz, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
